// File: rtl/grant_responder_if.sv
// Arbiter-to-responder handshake bundle: per-port request fields in, completion and read data out.
interface grant_responder_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 4
);
   logic [3:0]      grant;
   logic [3:0]      we;
   logic [4*AW-1:0] addr;
   logic [4*DW-1:0] wdata;
   logic            ack;
   logic [3:0]      done;
   logic [DW-1:0]   rdata;
   logic            busy;
   logic            err;

   modport master (
      output grant, we, addr, wdata,
      input  ack, done, rdata, busy, err
   );

   modport slave (
      input  grant, we, addr, wdata,
      output ack, done, rdata, busy, err
   );
endinterface

// File: rtl/grant_responder.sv
// Services one arbiter-granted port per transaction against a shared register file,
// with programmable wait states, a one-cycle ack pulse and a guard cycle afterwards.
module grant_responder #(
   parameter int unsigned DW          = 32,
   parameter int unsigned AW          = 4,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic              clk,
   input logic              rst_a,
   grant_responder_if.slave bus
);
   localparam int unsigned Depth   = 1 << AW;
   localparam logic [3:0]  CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StWait, StAck, StHold} state_e;

   state_e          state_q;
   logic [3:0]      cnt_q;
   logic [1:0]      idx_q;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [DW-1:0]   rdata_q;
   logic            ack_q;
   logic [3:0]      done_q;
   logic            busy_q;
   logic            err_q;
   logic [DW-1:0]   mem_q [Depth];

   logic            grant_one;
   logic            grant_multi;
   logic [1:0]      sel_idx;
   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (bus.grant[i]) sel_idx = 2'(i);
      end
   end

   assign grant_one   = $onehot(bus.grant);
   assign grant_multi = (bus.grant != '0) && !grant_one;
   assign sel_we      = bus.we[sel_idx];
   assign sel_addr    = bus.addr[sel_idx*AW +: AW];
   assign sel_wdata   = bus.wdata[sel_idx*DW +: DW];

   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else begin
         ack_q  <= 1'b0;
         done_q <= '0;
         case (state_q)
            StIdle: begin
               if (grant_one) begin
                  idx_q   <= sel_idx;
                  we_q    <= sel_we;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  busy_q  <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     // No wait states: the live request is the latched one this edge.
                     state_q <= StAck;
                     ack_q   <= 1'b1;
                     done_q  <= 4'b0001 << sel_idx;
                     if (!sel_we) rdata_q <= mem_q[sel_addr];
                  end else begin
                     state_q <= StWait;
                     cnt_q   <= CntInit;
                  end
               end else if (grant_multi) begin
                  err_q <= 1'b1;
               end
            end
            StWait: begin
               if (cnt_q == 4'd0) begin
                  state_q <= StAck;
                  ack_q   <= 1'b1;
                  done_q  <= 4'b0001 << idx_q;
                  if (!we_q) rdata_q <= mem_q[addr_q];
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StAck: begin
               if (we_q) mem_q[addr_q] <= wdata_q;
               state_q <= StHold;
            end
            StHold: begin
               // Arbiter grant register still shows the old winner here.
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ack   = ack_q;
   assign bus.done  = done_q;
   assign bus.rdata = rdata_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;
endmodule

// File: tb/tb_grant_responder.sv
// Scoreboard bench: two responders (2 wait states and 0 wait states) driven by directed vectors.
module tb_grant_responder;
   typedef struct {
      logic [3:0]  done;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea;
   exp_t eb;

   grant_responder_if #(.DW(32), .AW(4)) ifa ();
   grant_responder_if #(.DW(32), .AW(4)) ifb ();

   grant_responder #(.DW(32), .AW(4), .WAIT_CYCLES(2)) dut_a (
      .clk   (clk),
      .rst_a (rst),
      .bus   (ifa)
   );

   grant_responder #(.DW(32), .AW(4), .WAIT_CYCLES(0)) dut_b (
      .clk   (clk),
      .rst_a (rst),
      .bus   (ifb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: every ack pops one expected response.
   always @(negedge clk) begin
      if (!rst) begin
         if (ifa.ack) begin
            if (qa.size() == 0) check("a_unexpected_ack", 32'(ifa.ack), 32'd0);
            else begin
               ea = qa.pop_front();
               check("a_done", 32'(ifa.done), 32'(ea.done));
               check("a_rdata", ifa.rdata, ea.rdata);
               check("a_ack_cycle", cyc, ea.cyc);
            end
         end else if (ifa.done != 4'd0) check("a_done_without_ack", 32'(ifa.done), 32'd0);
         if (ifb.ack) begin
            if (qb.size() == 0) check("b_unexpected_ack", 32'(ifb.ack), 32'd0);
            else begin
               eb = qb.pop_front();
               check("b_done", 32'(ifb.done), 32'(eb.done));
               check("b_rdata", ifb.rdata, eb.rdata);
               check("b_ack_cycle", cyc, eb.cyc);
            end
         end else if (ifb.done != 4'd0) check("b_done_without_ack", 32'(ifb.done), 32'd0);
      end
   end

   // One granted cycle, then the request fields are scrambled to prove they were latched.
   task automatic txn(input bit b, input int p, input bit w, input logic [3:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd);
      int   n;
      int   wc;
      exp_t e;
      wc = b ? 0 : 2;
      @(posedge clk); #1;
      if (b) begin
         ifb.grant = 4'(1 << p); ifb.we[p] = w; ifb.addr[p*4 +: 4] = a; ifb.wdata[p*32 +: 32] = d;
      end else begin
         ifa.grant = 4'(1 << p); ifa.we[p] = w; ifa.addr[p*4 +: 4] = a; ifa.wdata[p*32 +: 32] = d;
      end
      n = cyc;
      e.done  = 4'(1 << p);
      e.rdata = exp_rd;
      e.cyc   = n + 1 + wc;
      if (b) qb.push_back(e);
      else qa.push_back(e);
      @(posedge clk); #1;
      if (b) begin
         ifb.grant = 4'd0; ifb.we[p] = ~w; ifb.addr[p*4 +: 4] = ~a; ifb.wdata[p*32 +: 32] = ~d;
      end else begin
         ifa.grant = 4'd0; ifa.we[p] = ~w; ifa.addr[p*4 +: 4] = ~a; ifa.wdata[p*32 +: 32] = ~d;
      end
      repeat (wc + 2) @(negedge clk);
      check(b ? "b_busy_hold" : "a_busy_hold", 32'(b ? ifb.busy : ifa.busy), 32'd1);
      @(negedge clk);
      check(b ? "b_busy_idle" : "a_busy_idle", 32'(b ? ifb.busy : ifa.busy), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ack"}, 32'(ifa.ack), 32'd0);
      check({tag, "_done"}, 32'(ifa.done), 32'd0);
      check({tag, "_rdata"}, ifa.rdata, 32'd0);
      check({tag, "_busy"}, 32'(ifa.busy), 32'd0);
      check({tag, "_err"}, 32'(ifa.err), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int n;
      exp_t e;
      ifa.grant = '0; ifa.we = '0; ifa.addr = '0; ifa.wdata = '0;
      ifb.grant = '0; ifb.we = '0; ifb.addr = '0; ifb.wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst_init");
      rst = 1'b0;

      // Two wait states: write, read-back, wrap of scrambled fields
      txn(0, 1, 1'b0, 4'd3,  32'h0,        32'h0);
      txn(0, 0, 1'b1, 4'd3,  32'hDEADBEEF, 32'h0);
      txn(0, 2, 1'b0, 4'd3,  32'h0,        32'hDEADBEEF);
      txn(0, 3, 1'b1, 4'd15, 32'h12345678, 32'hDEADBEEF);
      txn(0, 1, 1'b1, 4'd5,  32'hA5A50001, 32'hDEADBEEF);
      txn(0, 0, 1'b0, 4'd15, 32'h0,        32'h12345678);
      txn(0, 3, 1'b0, 4'd5,  32'h0,        32'hA5A50001);
      txn(0, 1, 1'b0, 4'd10, 32'h0,        32'h0);

      // Multi-hot grant: flags err, performs no access
      @(posedge clk); #1;
      ifa.grant = 4'b0110; ifa.we = 4'b0110;
      ifa.addr[4 +: 4] = 4'd3; ifa.addr[8 +: 4] = 4'd3;
      ifa.wdata[32 +: 32] = 32'h11111111; ifa.wdata[64 +: 32] = 32'h22222222;
      @(posedge clk); #1;
      ifa.grant = 4'd0;
      repeat (4) @(negedge clk);
      check("err_set", 32'(ifa.err), 32'd1);
      check("err_no_busy", 32'(ifa.busy), 32'd0);
      txn(0, 2, 1'b0, 4'd3, 32'h0, 32'hDEADBEEF);
      check("err_sticky", 32'(ifa.err), 32'd1);

      // Reset during WAIT of a write
      @(posedge clk); #1;
      ifa.grant = 4'b0001; ifa.we[0] = 1'b1; ifa.addr[0 +: 4] = 4'd7; ifa.wdata[0 +: 32] = 32'hCAFE;
      @(posedge clk); #1;
      ifa.grant = 4'd0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      txn(0, 0, 1'b0, 4'd7, 32'h0,    32'h0);
      txn(0, 1, 1'b0, 4'd3, 32'h0,    32'h0);
      txn(0, 0, 1'b1, 4'd7, 32'hCAFE, 32'h0);
      txn(0, 3, 1'b0, 4'd7, 32'h0,    32'hCAFE);

      // Zero wait states: write, then a held grant acks every third cycle
      txn(1, 3, 1'b1, 4'd2, 32'h0BADF00D, 32'h0);
      @(posedge clk); #1;
      ifb.grant = 4'b1000; ifb.we[3] = 1'b0; ifb.addr[12 +: 4] = 4'd2;
      n = cyc;
      for (int k = 0; k < 4; k++) begin
         e.done  = 4'b1000;
         e.rdata = 32'h0BADF00D;
         e.cyc   = n + 1 + 3 * k;
         qb.push_back(e);
      end
      repeat (10) @(posedge clk);
      #1;
      ifb.grant = 4'd0;
      repeat (5) @(negedge clk);
      check("b_idle_after_hold", 32'(ifb.busy), 32'd0);

      check("qa_drained", 32'(qa.size()), 32'd0);
      check("qb_drained", 32'(qb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/grant_responder.md
GRANT_RESPONDER -- requirements
Module: grant_responder

Interface
REQ-001 SHALL have parameter DW, default 32: data width of the shared register file.
REQ-002 SHALL have parameter AW, default 4: address width; file depth is 2**AW entries.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, legal range 0..15: access wait states inserted before ack.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_a, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port grant, input, 4: registered one-hot grant from the 4-port round-robin arbiter.
REQ-007 SHALL have port we, input, 4: per-port write enable; 1 = write, 0 = read.
REQ-008 SHALL have port addr, input, 4*AW: per-port address; port i uses slice [i*AW +: AW].
REQ-009 SHALL have port wdata, input, 4*DW: per-port write data; port i uses slice [i*DW +: DW].
REQ-010 SHALL have port ack, output, 1: one-cycle completion pulse back to the arbiter.
REQ-011 SHALL have port done, output, 4: one-hot completion flag to the serviced port, high only with ack.
REQ-012 SHALL have port rdata, output, DW: read result, registered.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port err, output, 1: sticky flag for an illegal (multi-hot) grant.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACK and HOLD.
REQ-016 In IDLE with exactly one grant bit set, SHALL latch port index, we, addr and wdata of that port.
REQ-017 From IDLE after such a latch, SHALL go to WAIT with counter = WAIT_CYCLES-1, or go directly to ACK when WAIT_CYCLES = 0.
REQ-018 In IDLE with grant = 0, SHALL stay in IDLE with no side effects.
REQ-019 In IDLE with more than one grant bit set, SHALL set err, stay in IDLE and perform no access.
REQ-020 In WAIT, SHALL decrement the counter each cycle and go to ACK in the cycle after the counter reads 0.
REQ-021 In ACK, SHALL assert ack = 1 and done[idx] = 1 for exactly one cycle, then go to HOLD.
REQ-022 In HOLD, SHALL ignore grant for exactly one cycle, then return to IDLE.
REQ-023 HOLD SHALL cover the cycle in which the arbiter grant register still reflects the pre-rotation winner.
REQ-024 Latency: grant sampled in IDLE at cycle n SHALL produce ack at cycle n+1+WAIT_CYCLES.
REQ-025 Next possible IDLE sample after that grant SHALL be at cycle n+3+WAIT_CYCLES.
REQ-026 Read: rdata SHALL be loaded from mem[latched addr] on the edge entering ACK, be valid while ack = 1, and hold until the next read ACK.
REQ-027 Write: mem[latched addr] SHALL be updated with the latched wdata on the edge ending the ACK cycle.
REQ-028 A write SHALL leave rdata unchanged.
REQ-029 Changes on grant, we, addr or wdata after the latch in REQ-016 SHALL NOT affect the transaction in progress.
REQ-030 A grant that drops mid-transaction SHALL NOT abort it.
REQ-031 Address SHALL wrap modulo 2**AW; there SHALL be no out-of-range condition.
REQ-032 err SHALL clear only on reset.

Reset
REQ-033 While rst_a = 1, regardless of clk: state = IDLE, ack = 0, done = 0, rdata = 0, busy = 0, err = 0, counter = 0, all mem entries = 0.
REQ-034 Reset asserted mid-transaction SHALL abort it with no mem write and no ack.
REQ-035 The first grant SHALL be sampled on the first rising edge after rst_a deasserts.

Verification
REQ-036 Scenario, WAIT_CYCLES = 2: grant = 0001, we[0] = 1, addr0 = 3, wdata0 = 0xDEADBEEF at cycle n -> ack and done = 0001 at n+3; mem[3] = 0xDEADBEEF; busy low at n+5.
REQ-037 Scenario, read-back: port 2 reads addr 3 after REQ-036 -> rdata = 0xDEADBEEF with ack and done = 0100.
REQ-038 Scenario, WAIT_CYCLES = 0: grant = 1000 held constantly -> ack pulses every 3 cycles, never on consecutive cycles.
REQ-039 Scenario: grant = 0110 in IDLE -> err = 1, no ack, mem unchanged; err remains 1 after later legal transactions.
REQ-040 Scenario: addr0 and wdata0 change and grant drops to 0000 during WAIT -> the originally latched address and data are committed and ack still fires.
REQ-041 Scenario: rst_a pulsed during WAIT of a write -> outputs 0 immediately, target mem entry stays 0, next transaction completes normally.
